rw_request_arbiter: RTL and testbench
=====================================

# rw_request_arbiter

Sits directly downstream of the read and write request FIFOs. Picks which FIFO to pop and forwards one frontend command at a time to the command-issue stage through a valid/ready handshake. Write flushes (watermark or read-after-write hazard) take precedence over reads. A programmable bus-turnaround gap is inserted on every read↔write direction change.

## Interface
- TURNAROUND_CYCLES, default 4: idle cycles inserted after the last command of one direction is accepted and before the first command of the other direction is popped.
- IDLE_WRITE_EN, default 1: when 1, writes drain opportunistically while the read FIFO is empty, even without a flush.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rd_fifo_data  in  frontend_command_t  head of the read FIFO (combinational, valid when not empty).
- i_rd_fifo_empty  in  1  read FIFO empty.
- o_rd_fifo_rd_en  out  1  pop the read FIFO (combinational).
- i_wr_fifo_data  in  frontend_command_t  head of the write FIFO.
- i_wr_fifo_empty  in  1  write FIFO empty.
- i_write_flush  in  1  write FIFO demands draining; held by the FIFO until it is empty.
- o_wr_fifo_rd_en  out  1  pop the write FIFO (combinational).
- o_cmd  out  frontend_command_t  command to the issue stage (registered).
- o_cmd_valid  out  1  o_cmd is valid.
- i_cmd_ready  in  1  issue stage accepts o_cmd this cycle.
- o_write_mode  out  1  1 while in TURN_R2W or WRITE (registered).

## Operation
- States:
  - READ: pops reads only.
  - TURN_R2W: gap before writes.
  - WRITE: pops writes only.
  - TURN_W2R: gap before reads.
- Output stage is a one-entry register. It is free when !o_cmd_valid or (o_cmd_valid && i_cmd_ready).
- Pop rules:
  - READ: o_rd_fifo_rd_en = free && !i_rd_fifo_empty && !i_write_flush.
  - WRITE: o_wr_fifo_rd_en = free && !i_wr_fifo_empty.
  - TURN states: never pop.
  - At most one FIFO is popped per cycle. Both enables are 0 in reset.
- On a pop, the popped FIFO's head is loaded into o_cmd and o_cmd_valid is set next cycle. Otherwise, acceptance (i_cmd_ready) clears o_cmd_valid.
- READ → TURN_R2W when i_write_flush, or when IDLE_WRITE_EN && i_rd_fifo_empty && !i_wr_fifo_empty. No read is popped in the transition cycle.
- WRITE → TURN_W2R when !i_write_flush && (i_wr_fifo_empty || !i_rd_fifo_empty). No write is popped in the transition cycle.
- While i_write_flush is high, WRITE is never left, even if reads are waiting.
- TURN states:
  - The counter loads TURNAROUND_CYCLES on entry.
  - It decrements only on cycles where o_cmd_valid == 0.
  - The state exits to the target mode on the first cycle the counter is 0 and o_cmd_valid == 0.
  - With TURNAROUND_CYCLES = 0, exit occurs on the first cycle the output register is empty.
- The turnaround counter width is $clog2(TURNAROUND_CYCLES+1), minimum 1. It saturates at 0 and never wraps.
- Reset values: state READ, counter 0, o_cmd all-zero, o_cmd_valid 0, o_write_mode 0.
- Reset asserted mid-operation discards the held command. No partial pop occurs, because enables are combinational from the reset state.

## Timing
- Pop-to-valid latency is 1 cycle: a pop at cycle N gives o_cmd_valid at N+1.
- Back-to-back throughput is 1 command/cycle within a mode while i_cmd_ready is held high.
- Direction change: last old-direction acceptance at cycle A, then the first new-direction pop at cycle A + 1 + TURNAROUND_CYCLES, then valid one cycle later.
- o_cmd is stable while o_cmd_valid && !i_cmd_ready; o_cmd_valid never drops without acceptance.
- i_write_flush rising at cycle N blocks any read pop at cycle N, so a read never overtakes a flushing write.

## Structure
- arb_state_t enum (READ, TURN_R2W, WRITE, TURN_W2R) goes into frontend_command_definition_pkg next to frontend_command_t.
- One natural sub-module, cmd_out_stage: the one-entry registered output with its free signal. The FSM and turnaround counter stay in the top module.

## Test plan
- Reset, then 3 reads (rows 1, 2, 3) with i_cmd_ready = 1, no writes → pops on 3 consecutive cycles, o_cmd_valid for 3 cycles in order, o_write_mode stays 0.
- Read FIFO holding 2 entries, flush raised at cycle 10, write FIFO holding 4 entries, TURNAROUND_CYCLES = 4 → no read pop from cycle 10. Writes are popped starting 5 cycles after the in-flight read is accepted, all 4 are forwarded, then TURN_W2R (4 idle cycles), then the 2 reads.
- Backpressure: i_cmd_ready = 0 for 6 cycles with the read FIFO non-empty → exactly 1 pop, o_cmd constant for 6 cycles, next pop in the cycle ready returns.
- IDLE_WRITE_EN = 1, read FIFO empty, 1 write queued, no flush → write forwarded after the 4-cycle gap. A read arriving during WRITE causes a return to READ after the write FIFO's current pop and the gap.
- TURNAROUND_CYCLES = 0: alternate the flush with 1 write and 1 read queued → direction changes with no idle cycle beyond the output-register drain.
- Assert i_rst_n low while o_cmd_valid = 1 in WRITE → o_cmd_valid = 0, o_write_mode = 0, state READ immediately, no FIFO pop during reset.

Source files
------------

// File: rtl/frontend_command_definition_pkg.sv
// Shared types for the frontend command path: the command word handed from the
// request FIFOs to the issue stage, and the read/write arbiter state encoding.
package frontend_command_definition_pkg;

  typedef struct packed {
    logic [2:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
    logic [7:0]  id;
    logic        is_write;
  } frontend_command_t;

  typedef enum logic [1:0] {
    READ     = 2'd0,
    TURN_R2W = 2'd1,
    WRITE    = 2'd2,
    TURN_W2R = 2'd3
  } arb_state_t;

  // A zero-cycle turnaround still needs a one-bit counter to hold the value 0.
  function automatic int turn_cnt_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/cmd_out_stage.sv
// One-entry registered output toward the issue stage. The slot is free when it
// is empty or its current command is being accepted this cycle.
module cmd_out_stage
  import frontend_command_definition_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              load,
  input  frontend_command_t load_data,
  input  logic              ready,
  output frontend_command_t cmd,
  output logic              cmd_valid,
  output logic              free
);

  frontend_command_t cmd_reg;
  logic              valid_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      cmd_reg   <= load_data;
      valid_reg <= 1'b1;
    end else if (ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign cmd       = cmd_reg;
  assign cmd_valid = valid_reg;
  assign free      = !valid_reg || ready;

endmodule

// File: rtl/rw_request_arbiter.sv
// Chooses between the read and write request FIFOs, gives write flushes
// precedence, and inserts a programmable bus-turnaround gap on direction changes.
module rw_request_arbiter
  import frontend_command_definition_pkg::*;
#(
  parameter int TURNAROUND_CYCLES = 4,
  parameter bit IDLE_WRITE_EN     = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  frontend_command_t i_rd_fifo_data,
  input  logic              i_rd_fifo_empty,
  output logic              o_rd_fifo_rd_en,
  input  frontend_command_t i_wr_fifo_data,
  input  logic              i_wr_fifo_empty,
  input  logic              i_write_flush,
  output logic              o_wr_fifo_rd_en,
  output frontend_command_t o_cmd,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic              o_write_mode
);

  localparam int CNT_W = turn_cnt_width(TURNAROUND_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURNAROUND_CYCLES);

  arb_state_t       state_reg, state_next, mode;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             write_mode_reg;
  logic             free, turn_done, switch_dir, rd_pop, wr_pop;

  assign turn_done = (cnt_reg == '0) && !o_cmd_valid;

  // The cycle a turnaround expires already behaves as the target mode, so the
  // first new-direction pop lands exactly TURNAROUND_CYCLES idle cycles after
  // the last old-direction acceptance.
  always_comb begin
    mode = state_reg;
    if (state_reg == TURN_R2W && turn_done) mode = WRITE;
    if (state_reg == TURN_W2R && turn_done) mode = READ;
  end

  always_comb begin
    state_next = mode;
    cnt_next   = cnt_reg;
    switch_dir = 1'b0;
    rd_pop     = 1'b0;
    wr_pop     = 1'b0;
    case (mode)
      READ: begin
        switch_dir = i_write_flush ||
                     (IDLE_WRITE_EN && i_rd_fifo_empty && !i_wr_fifo_empty);
        rd_pop     = free && !i_rd_fifo_empty && !i_write_flush;
        if (switch_dir) begin
          state_next = TURN_R2W;
          cnt_next   = CNT_LOAD;
        end
      end
      WRITE: begin
        switch_dir = !i_write_flush && (i_wr_fifo_empty || !i_rd_fifo_empty);
        wr_pop     = free && !i_wr_fifo_empty && !switch_dir;
        if (switch_dir) begin
          state_next = TURN_W2R;
          cnt_next   = CNT_LOAD;
        end
      end
      default: begin
        if (!o_cmd_valid && cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= READ;
      cnt_reg        <= '0;
      write_mode_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      write_mode_reg <= (state_next == TURN_R2W) || (state_next == WRITE);
    end
  end

  assign o_rd_fifo_rd_en = i_rst_n && rd_pop;
  assign o_wr_fifo_rd_en = i_rst_n && wr_pop;
  assign o_write_mode    = write_mode_reg;

  cmd_out_stage u_out (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .load      (o_rd_fifo_rd_en || o_wr_fifo_rd_en),
    .load_data (o_wr_fifo_rd_en ? i_wr_fifo_data : i_rd_fifo_data),
    .ready     (i_cmd_ready),
    .cmd       (o_cmd),
    .cmd_valid (o_cmd_valid),
    .free      (free)
  );

endmodule

// File: tb/tb_rw_request_arbiter.sv
// Drives two arbiter instances (turnaround 4 and 0) from FIFO queues and checks
// them every cycle against a direction/gap model plus literal pop-cycle masks.
module tb_rw_request_arbiter;
  import frontend_command_definition_pkg::*;

  localparam bit IDLE = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input int ch, input int cyc, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL ch%0d cyc %0d %s: got %0h expected %0h", ch, cyc, name, act, exp);
    end
  endfunction

  function automatic frontend_command_t mk_cmd(input logic w, input logic [15:0] row);
    frontend_command_t c;
    c.bank     = 3'($urandom);
    c.row      = row;
    c.col      = 10'($urandom);
    c.id       = 8'($urandom);
    c.is_write = w;
    return c;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    localparam int T = (gi == 0) ? 4 : 0;

    logic              rst_n = 1'b1;
    frontend_command_t rd_data, wr_data, cmd;
    logic              rd_empty, wr_empty, flush, rd_en, wr_en;
    logic              cmd_valid, ready, write_mode;
    logic              done = 1'b0;

    frontend_command_t rd_q[$];
    frontend_command_t wr_q[$];
    logic              flush_arm;
    int                cyc;
    logic [63:0]       rd_mask, wr_mask;

    // model: current/target direction, whether a gap is running, idle cycles seen
    logic              m_dir, m_sw, m_valid;
    int                m_idle;
    frontend_command_t m_cmd;

    rw_request_arbiter #(
      .TURNAROUND_CYCLES (T),
      .IDLE_WRITE_EN     (IDLE)
    ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_rd_fifo_data  (rd_data),
      .i_rd_fifo_empty (rd_empty),
      .o_rd_fifo_rd_en (rd_en),
      .i_wr_fifo_data  (wr_data),
      .i_wr_fifo_empty (wr_empty),
      .i_write_flush   (flush),
      .o_wr_fifo_rd_en (wr_en),
      .o_cmd           (cmd),
      .o_cmd_valid     (cmd_valid),
      .i_cmd_ready     (ready),
      .o_write_mode    (write_mode)
    );

    task automatic drive();
      rd_empty = (rd_q.size() == 0);
      wr_empty = (wr_q.size() == 0);
      rd_data  = rd_empty ? '0 : rd_q[0];
      wr_data  = wr_empty ? '0 : wr_q[0];
      flush    = flush_arm && !wr_empty;
    endtask

    task automatic step();
      logic free, gap_over, sw_eff, want, erd, ewr, was_valid;
      drive();
      #1;
      if (!rst_n) begin
        m_dir = 1'b0; m_sw = 1'b0; m_valid = 1'b0; m_idle = 0; m_cmd = '0;
        check(gi, cyc, "rst_rd_en", 64'(rd_en), 64'd0);
        check(gi, cyc, "rst_wr_en", 64'(wr_en), 64'd0);
        check(gi, cyc, "rst_valid", 64'(cmd_valid), 64'd0);
        check(gi, cyc, "rst_wmode", 64'(write_mode), 64'd0);
        check(gi, cyc, "rst_cmd", 64'(cmd), 64'd0);
      end else begin
        free     = !m_valid || ready;
        gap_over = m_sw && !m_valid && (m_idle >= T);
        sw_eff   = m_sw && !gap_over;
        want = 1'b0; erd = 1'b0; ewr = 1'b0;
        if (!sw_eff) begin
          if (!m_dir) begin
            want = flush || (IDLE && rd_empty && !wr_empty);
            erd  = free && !rd_empty && !flush;
          end else begin
            want = !flush && (wr_empty || !rd_empty);
            ewr  = free && !wr_empty && !want;
          end
        end
        check(gi, cyc, "rd_en", 64'(rd_en), 64'(erd));
        check(gi, cyc, "wr_en", 64'(wr_en), 64'(ewr));
        check(gi, cyc, "cmd_valid", 64'(cmd_valid), 64'(m_valid));
        check(gi, cyc, "write_mode", 64'(write_mode), 64'(m_dir));
        if (m_valid) check(gi, cyc, "cmd", 64'(cmd), 64'(m_cmd));
        if (rd_en && cyc < 64) rd_mask[cyc] = 1'b1;
        if (wr_en && cyc < 64) wr_mask[cyc] = 1'b1;

        was_valid = m_valid;
        if (erd) begin
          m_cmd = rd_q.pop_front(); m_valid = 1'b1;
        end else if (ewr) begin
          m_cmd = wr_q.pop_front(); m_valid = 1'b1;
        end else if (ready) begin
          m_valid = 1'b0;
        end
        if (sw_eff) begin
          if (!was_valid) m_idle++;
        end else if (want) begin
          m_dir = !m_dir; m_sw = 1'b1; m_idle = 0;
        end else begin
          m_sw = 1'b0;
        end
      end
      cyc++;
      @(negedge clk);
    endtask

    task automatic begin_phase();
      cyc = 0; rd_mask = '0; wr_mask = '0;
    endtask

    task automatic end_phase(input logic [63:0] exp_rd, input logic [63:0] exp_wr,
                             input string tag);
      check(gi, cyc, {tag, "_rd_pops"}, rd_mask, exp_rd);
      check(gi, cyc, {tag, "_wr_pops"}, wr_mask, exp_wr);
    endtask

    task automatic intro();
      rst_n = 1'b0; ready = 1'b0; flush_arm = 1'b0; cyc = 0;
      rd_q.delete(); wr_q.delete();
      drive();
      @(negedge clk);
      step(); step();
      rst_n = 1'b1;
      begin_phase();
      ready = 1'b1;
      for (int r = 1; r <= 3; r++) rd_q.push_back(mk_cmd(1'b0, 16'(r)));
      repeat (6) step();
      end_phase(64'h7, 64'h0, "three_reads");
    endtask

    task automatic random_phase(input int n);
      begin_phase();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) < 3 && rd_q.size() < 8) rd_q.push_back(mk_cmd(1'b0, 16'($urandom)));
        if ($urandom_range(0, 9) < 3 && wr_q.size() < 8) wr_q.push_back(mk_cmd(1'b1, 16'($urandom)));
        ready = ($urandom_range(0, 3) != 0);
        if (wr_q.size() >= 5 || $urandom_range(0, 39) == 0) flush_arm = 1'b1;
        if (wr_q.size() == 0) flush_arm = 1'b0;
        step();
      end
    endtask

    if (gi == 0) begin : g_t4
      initial begin
        intro();
        // flush rises with a read in flight
        begin_phase();
        ready = 1'b1;
        rd_q.push_back(mk_cmd(1'b0, 16'd10));
        rd_q.push_back(mk_cmd(1'b0, 16'd11));
        for (int w = 0; w < 4; w++) wr_q.push_back(mk_cmd(1'b1, 16'(20 + w)));
        for (int c = 0; c < 20; c++) begin
          if (c == 1) flush_arm = 1'b1;
          step();
        end
        flush_arm = 1'b0;
        end_phase(64'h8001, 64'h3c0, "flush");
        // backpressure
        begin_phase();
        rd_q.push_back(mk_cmd(1'b0, 16'd50));
        rd_q.push_back(mk_cmd(1'b0, 16'd51));
        for (int c = 0; c < 10; c++) begin
          ready = (c >= 6);
          step();
        end
        end_phase(64'h41, 64'h0, "backpressure");
        // idle write drain, then a read pulls the arbiter back
        begin_phase();
        ready = 1'b1;
        wr_q.push_back(mk_cmd(1'b1, 16'd30));
        for (int c = 0; c < 14; c++) begin
          if (c == 6) rd_q.push_back(mk_cmd(1'b0, 16'd31));
          step();
        end
        end_phase(64'h800, 64'h20, "idle_write");
        // reset while a write is held
        begin_phase();
        for (int w = 0; w < 3; w++) wr_q.push_back(mk_cmd(1'b1, 16'(60 + w)));
        flush_arm = 1'b1;
        ready = 1'b0;
        repeat (8) step();
        end_phase(64'h0, 64'h20, "pre_reset");
        check(gi, cyc, "held_valid", 64'(cmd_valid), 64'd1);
        check(gi, cyc, "held_wmode", 64'(write_mode), 64'd1);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        ready = 1'b1;
        random_phase(2500);
        done = 1'b1;
      end
    end else begin : g_t0
      initial begin
        intro();
        // alternate directions with no turnaround gap
        begin_phase();
        ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
          if (c == 0 || c == 5) begin
            wr_q.push_back(mk_cmd(1'b1, 16'(40 + c)));
            rd_q.push_back(mk_cmd(1'b0, 16'(41 + c)));
            flush_arm = 1'b1;
          end
          step();
        end
        flush_arm = 1'b0;
        end_phase(64'h108, 64'h42, "t0_alternate");
        random_phase(2500);
        done = 1'b1;
      end
    end
  end

  initial begin
    fork
      wait (g_ch[0].done && g_ch[1].done);
      #1_000_000;
    join_any
    disable fork;
    if (!(g_ch[0].done && g_ch[1].done)) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: done flags got %b%b expected 11", g_ch[0].done, g_ch[1].done);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
